// File: rtl/module_bintobcd_seq.sv
// module_bintobcd_seq: one-bit-per-cycle double-dabble binary-to-BCD converter with valid/ready on both sides and overflow saturation; define BCD_BLANK_EN to add the digit_blank leading-zero mask output
module module_bintobcd_seq #(
  parameter int WIDTH_IN   = 8,
  parameter int NUM_DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH_IN-1:0]     bin_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic                    overflow
`ifdef BCD_BLANK_EN
  ,
  output logic [NUM_DIGITS-1:0]   digit_blank
`endif
);
  localparam int BW = 4*NUM_DIGITS;
  localparam int CW = $clog2(WIDTH_IN+1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  state_e              state_q, state_d;
  logic [WIDTH_IN-1:0] bin_q, bin_d, bin_sh;
  logic [BW-1:0]       bcd_q, bcd_d, bcd_sh, adj;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                ovf_acc_q, ovf_acc_d, sh_out;
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  // next state: accept in IDLE, count out WIDTH_IN shifts, wait for consumer in DONE
  always_comb begin
    state_d = state_q == IDLE  ? (in_valid ? SHIFT : IDLE) :
              state_q == SHIFT ? (cnt_q == CW'(1) ? DONE : SHIFT) :
                                 (out_ready ? IDLE : DONE);
  end
  // handshake outputs and the saturated result view
  always_comb begin
    in_ready  = state_q == IDLE;
    out_valid = state_q == DONE;
    overflow  = ovf_acc_q;
    bcd_out   = ovf_acc_q ? {NUM_DIGITS{4'h9}} : bcd_q;
  end
  // datapath next state: add-3 on digits >=5, then shift {bcd,bin} left, collecting lost top bits
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++)
      adj[4*i +: 4] = bcd_q[4*i +: 4] >= 4'd5 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    {sh_out, bcd_sh, bin_sh} = {adj, bin_q, 1'b0};
    bin_d     = state_q == IDLE && in_valid ? bin_in        : state_q == SHIFT ? bin_sh              : bin_q;
    bcd_d     = state_q == IDLE && in_valid ? '0            : state_q == SHIFT ? bcd_sh              : bcd_q;
    ovf_acc_d = state_q == IDLE && in_valid ? 1'b0          : state_q == SHIFT ? ovf_acc_q | sh_out  : ovf_acc_q;
    cnt_d     = state_q == IDLE && in_valid ? CW'(WIDTH_IN) : state_q == SHIFT ? cnt_q - CW'(1)      : cnt_q;
  end
  // datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q     <= '0;
      bcd_q     <= '0;
      ovf_acc_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      ovf_acc_q <= ovf_acc_d;
      cnt_q     <= cnt_d;
    end
  end
`ifdef BCD_BLANK_EN
  logic [NUM_DIGITS-1:0] blank_q, blank_d;
  logic                  zero;
  // build the leading-zero mask from the final digits on the last shift; units digit never blanks
  always_comb begin
    blank_d = blank_q;
    zero    = 1'b1;
    if (state_q == SHIFT && cnt_q == CW'(1)) begin
      for (int i = NUM_DIGITS-1; i >= 0; i--) begin
        zero       = zero & (bcd_d[4*i +: 4] == 4'd0);
        blank_d[i] = (i != 0) && zero && !ovf_acc_d;
      end
    end
  end
  // blank mask register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blank_q <= '0;
    else blank_q <= blank_d;
  end
  assign digit_blank = blank_q;
`endif
endmodule

// File: tb/tb_module_bintobcd_seq.sv
// tb_module_bintobcd_seq: random and directed checks of the converter (3-digit and 2-digit instances) against an arithmetic model
module tb_module_bintobcd_seq;
  localparam int W = 8;
  logic clk = 0;
  logic rst_n = 0;
  logic in_valid = 0;
  logic out_ready = 0;
  logic [W-1:0] bin_in = '0;
  logic in_ready, out_valid, overflow, in_ready2, out_valid2, overflow2;
  logic [11:0] bcd_out;
  logic [7:0] bcd_out2;
`ifdef BCD_BLANK_EN
  logic [2:0] blank3;
  logic [1:0] blank2;
`endif
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit rec = 0;
  logic [11:0] q_bcd[$];
  int q_cyc[$];
  int r_lat;
  logic [11:0] r_b3;
  logic [7:0] r_b2;
  logic r_o3, r_o2;
  logic [2:0] r_k3;
  logic [1:0] r_k2;

  module_bintobcd_seq #(.WIDTH_IN(W), .NUM_DIGITS(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .bin_in(bin_in),
    .out_valid(out_valid), .out_ready(out_ready), .bcd_out(bcd_out), .overflow(overflow)
`ifdef BCD_BLANK_EN
    , .digit_blank(blank3)
`endif
  );
  module_bintobcd_seq #(.WIDTH_IN(W), .NUM_DIGITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .bin_in(bin_in),
    .out_valid(out_valid2), .out_ready(out_ready), .bcd_out(bcd_out2), .overflow(overflow2)
`ifdef BCD_BLANK_EN
    , .digit_blank(blank2)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int unsigned pow10(input int n);
    int unsigned p = 1;
    for (int i = 0; i < n; i++) p *= 10;
    return p;
  endfunction

  function automatic logic [31:0] exp_bcd(input int unsigned v, input int n);
    logic [31:0] r = 0;
    if (v >= pow10(n)) begin
      for (int i = 0; i < n; i++) r[4*i +: 4] = 4'h9;
      return r;
    end
    for (int i = 0; i < n; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_blank(input int unsigned v, input int n);
    logic [31:0] r = 0;
    if (v < pow10(n))
      for (int i = 1; i < n; i++) r[i] = v < pow10(i);
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // protocol model: busy from accept until consumed, valid WIDTH_IN edges after accept
  bit m_busy, m_valid;
  int m_wait;
  int unsigned m_val;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_valid <= 0; m_wait <= 0; m_val <= 0;
    end else if (!m_busy) begin
      if (in_valid) begin m_busy <= 1; m_val <= bin_in; m_wait <= W; end
    end else if (!m_valid) begin
      if (m_wait == 1) m_valid <= 1;
      m_wait <= m_wait - 1;
    end else if (out_ready) begin
      m_valid <= 0; m_busy <= 0;
    end
  end

  always @(negedge clk) if (rst_n) begin
    check("in_ready", in_ready, !m_busy);
    check("out_valid", out_valid, m_valid);
    check("in_ready2", in_ready2, !m_busy);
    check("out_valid2", out_valid2, m_valid);
    if (m_valid) begin
      check("bcd_out", bcd_out, exp_bcd(m_val, 3));
      check("overflow", overflow, m_val >= 1000);
      check("bcd_out2", bcd_out2, exp_bcd(m_val, 2));
      check("overflow2", overflow2, m_val >= 100);
`ifdef BCD_BLANK_EN
      check("blank3", blank3, exp_blank(m_val, 3));
      check("blank2", blank2, exp_blank(m_val, 2));
`endif
    end
    if (rec && out_valid && out_ready) begin
      q_bcd.push_back(bcd_out);
      q_cyc.push_back(cyc);
    end
  end

  task automatic run(input int v, input int hold);
    @(negedge clk);
    in_valid = 1; bin_in = W'(v); out_ready = 0;
    @(posedge clk); #1;
    in_valid = 0;
    r_lat = 0;
    while (!out_valid && r_lat < 50) begin
      @(posedge clk); #1;
      r_lat++;
      if (!out_valid) begin
        in_valid = 1'($urandom); bin_in = W'($urandom); out_ready = 1'($urandom);
      end
    end
    in_valid = 0; out_ready = 0;
    r_b3 = bcd_out; r_o3 = overflow; r_b2 = bcd_out2; r_o2 = overflow2;
`ifdef BCD_BLANK_EN
    r_k3 = blank3; r_k2 = blank2;
`else
    r_k3 = 0; r_k2 = 0;
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
    end
    check("held_bcd", bcd_out, r_b3);
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    check("idle_valid", out_valid, 0);
    check("idle_ready", in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_bcd", bcd_out, 0);
    check("rst_ovf", overflow, 0);
`ifdef BCD_BLANK_EN
    check("rst_blank", blank3, 0);
`endif
    @(negedge clk); rst_n = 1;
    run(255, 0);
    check("t1_lat", r_lat, 8);
    check("t1_bcd", r_b3, 12'h255);
    check("t1_ovf", r_o3, 0);
    run(0, 0);
    check("t2_bcd0", r_b3, 12'h000);
`ifdef BCD_BLANK_EN
    check("t2_blank0", r_k3, 3'b110);
`endif
    check("t2_lat0", r_lat, 8);
    run(9, 1);
    check("t2_bcd9", r_b3, 12'h009);
`ifdef BCD_BLANK_EN
    check("t2_blank9", r_k3, 3'b110);
`endif
    run(200, 0);
    check("t3_bcd2", r_b2, 8'h99);
    check("t3_ovf2", r_o2, 1);
    check("t3_bcd3", r_b3, 12'h200);
`ifdef BCD_BLANK_EN
    check("t3_blank2", r_k2, 2'b00);
`endif
    run(99, 0);
    check("t3_bcd99", r_b2, 8'h99);
    check("t3_ovf99", r_o2, 0);
    run(128, 5);
    check("t4_bcd", r_b3, 12'h128);
    // reset in the middle of a conversion of 77
    @(negedge clk);
    in_valid = 1; bin_in = 8'd77;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (4) @(posedge clk);
    #1 rst_n = 0;
    #1;
    check("t5_in_ready", in_ready, 1);
    check("t5_out_valid", out_valid, 0);
    check("t5_bcd", bcd_out, 0);
    check("t5_ovf", overflow, 0);
    @(negedge clk); rst_n = 1;
    run(77, 0);
    check("t5_bcd77", r_b3, 12'h077);
    // back-to-back conversions with in_valid held
    q_bcd.delete(); q_cyc.delete();
    @(negedge clk);
    rec = 1; out_ready = 1; in_valid = 1; bin_in = 8'd1;
    @(posedge clk); #1 bin_in = 8'd100;
    repeat (10) @(posedge clk);
    #1 bin_in = 8'd250;
    repeat (10) @(posedge clk);
    #1 in_valid = 0;
    repeat (12) @(posedge clk);
    #1 rec = 0; out_ready = 0;
    check("t6_count", q_bcd.size(), 3);
    if (q_bcd.size() == 3) begin
      check("t6_r0", q_bcd[0], 12'h001);
      check("t6_r1", q_bcd[1], 12'h100);
      check("t6_r2", q_bcd[2], 12'h250);
      check("t6_gap1", q_cyc[1] - q_cyc[0], 10);
      check("t6_gap2", q_cyc[2] - q_cyc[1], 10);
    end
    for (int i = 0; i < 40; i++) begin
      run(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
      check("rnd_lat", r_lat, 8);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
